mp_add_ctrl: RTL
================

MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

Interface
REQ-001 The block SHALL have parameter NWORDS, default 4, giving the number of 16-bit words per operand (legal 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: requests a new operation.
REQ-005 The block SHALL have port sub, input, 1 bit: selects subtract mode; it is ignored unless MP_ADD_SUB_EN is defined.
REQ-006 The block SHALL have ports a and b, input, 16*NWORDS bits each: the operands, with word 0 at bits [15:0].
REQ-007 The block SHALL have port cin, input, 1 bit: the carry into word 0.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress and not accepting start.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse that marks the result as valid.
REQ-010 The block SHALL have ports sum, output, 16*NWORDS bits, and cout, output, 1 bit: the result register and the final carry.

Function
REQ-011 The block SHALL time-share exactly one 16-bit adder across NWORDS cycles, chaining the carry through a carry register.
REQ-012 The FSM SHALL use three states: IDLE, RUN and DONE.
REQ-013 In IDLE, when start=1 is sampled at edge T, the block SHALL capture a, b and the effective carry-in, clear the word index, and enter RUN.
REQ-014 In RUN, at each edge the block SHALL compute word i (carry register + a[i] + b[i]), write sum word i, load the adder cout into the carry register, and increment i.
REQ-015 When i = NWORDS-1, the block SHALL take the final carry into cout and move to DONE.
REQ-016 RUN SHALL occupy cycles T+1..T+NWORDS, and done=1 SHALL be asserted only in cycle T+NWORDS+1 (DONE state).
REQ-017 After DONE, the FSM SHALL return to IDLE at T+NWORDS+2.
REQ-018 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-019 start SHALL be accepted only in IDLE; start in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 When start is held high continuously, the block SHALL begin one operation every NWORDS+2 cycles.
REQ-021 Changes on a, b, cin or sub after capture SHALL NOT affect the operation in progress.
REQ-022 During RUN, sum SHALL expose partially written words; sum and cout are defined only from the done cycle onward.
REQ-023 sum and cout SHALL hold their values until the next accepted start.
REQ-024 All arithmetic SHALL be modulo 2^(16*NWORDS), with the overflow carry reported on cout only.

Reset
REQ-025 When rst=1 is sampled at an edge, the next state SHALL be IDLE, with busy=0, done=0, sum=0, cout=0, carry register=0 and index=0.
REQ-026 Reset SHALL take priority over start.
REQ-027 Reset mid-operation SHALL abort the operation without producing a done pulse.

Configuration
REQ-028 Macro MP_ADD_SUB_EN SHALL control subtract mode.
REQ-029 When MP_ADD_SUB_EN is defined and sub=1 at capture, the block SHALL compute a - b as a + ~b + 1; cin SHALL be ignored and cout=1 SHALL mean no borrow.
REQ-030 When MP_ADD_SUB_EN is not defined, sub SHALL be unconnected internally, and the block SHALL contain no inversion logic and always add.

Structure
REQ-031 Package mp_add_pkg SHALL hold the constant WORD_W=16 and the state typedef (IDLE, RUN, DONE).
REQ-032 The block SHALL instantiate exactly one full_adder_16bit as its datapath sub-module; the FSM, index, carry and operand registers SHALL reside in mp_add_ctrl.

Verification (NWORDS=4)
REQ-033 Test 1: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0, start pulse at T -> busy from T+1, done at T+5, sum=0x0, cout=1, idle at T+6.
REQ-034 Test 2: a=0x158A, b=0x7095, cin=1 -> sum=0x0000_0000_0000_8620, cout=0.
REQ-035 Test 3: start Test 2, then at T+2 drive start=1 with a=b=0xFFFF...; change a and b at T+3 -> the first result is unchanged, there is exactly one done pulse, and no second operation runs.
REQ-036 Test 4: rst=1 at T+2 of an operation -> at the next edge busy=0, done=0, sum=0, cout=0, with no done pulse; a following Test 1 passes.
REQ-037 Test 5: start held high for 3 operations -> done pulses at T+5, T+11 and T+17.
REQ-038 Test 6: a=0x5, b=0x7, sub=1 -> with MP_ADD_SUB_EN, sum=0xFFFF_FFFF_FFFF_FFFE and cout=0; without MP_ADD_SUB_EN, sum=0xC and cout=0.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared constants and FSM state type for the multi-word adder controller.
package mp_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_add_ctrl_full_adder_16bit.sv
// Single 16-bit adder slice, time-shared by mp_add_ctrl across all operand words.
module full_adder_16bit
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, ci};

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-word adder: one 16-bit adder walks NWORDS words, carry chained through carry_r.
// Optional subtract mode (a + ~b + 1) is built only when MP_ADD_SUB_EN is defined.
module mp_add_ctrl
  import mp_add_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic [WORD_W*NWORDS-1:0] a,
  input  logic [WORD_W*NWORDS-1:0] b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_W*NWORDS-1:0] sum,
  output logic                     cout
);

  localparam int TOTAL_W = WORD_W * NWORDS;
  localparam int IDX_W   = $clog2(NWORDS);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry_r;
  logic [TOTAL_W-1:0] a_r, b_r;
  logic [TOTAL_W-1:0] b_eff;
  logic               cin_eff;
  logic               accept;
  logic               last;
  logic [WORD_W-1:0]  a_word, b_word, word_s;
  logic               word_co;

`ifdef MP_ADD_SUB_EN
  // Subtract folds into the add: invert b at capture and force the carry-in.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign cin_eff    = cin;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (idx == IDX_W'(NWORDS - 1));
  assign a_word = a_r[idx*WORD_W +: WORD_W];
  assign b_word = b_r[idx*WORD_W +: WORD_W];

  full_adder_16bit u_adder (
    .a  (a_word),
    .b  (b_word),
    .ci (carry_r),
    .s  (word_s),
    .co (word_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Operands are frozen at acceptance so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      carry_r <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      if (accept) begin
        idx     <= '0;
        carry_r <= cin_eff;
      end else if (state == RUN) begin
        sum[idx*WORD_W +: WORD_W] <= word_s;
        carry_r                   <= word_co;
        idx                       <= last ? '0 : idx + 1'b1;
        if (last) cout <= word_co;
      end
    end
  end

endmodule
